mem_bus_arbiter: RTL

- Shares the single CPU memory port (address / data / rw) between NUM_REQ requesters, e.g. instruction fetch, load/store unit and debug/DMA.
- Round-robin arbitration.
- Latches the winner's command and holds it on the memory port until memory acknowledges or a timeout fires.
- Returns read data and a completion pulse to the owner.
- Sits between the cpu core's fetch/store logic and the memory model.

---
 rtl/mem_bus_arbiter_pkg.sv | 21 ++
 rtl/mem_bus_arbiter_rr_picker.sv | 34 +++
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding and
// an index-width helper usable in parameter expressions.
package mem_bus_arbiter_pkg;

    // Arbiter FSM states; IDLE waits for requests, BUSY owns the memory port.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Round-robin picker: scans the request vector starting one past the last
// owner and wrapping, returning the first set bit. Purely combinational so
// it can be reused by other arbiters (e.g. an interrupt arbiter).
module mem_bus_arbiter_rr_picker
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_winner
);

    logic [IDX_W-1:0] w_idx;

    // Walk the requesters in priority order and keep the first one found.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        o_valid  = 1'b0;
        o_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_valid && i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one memory port among NUM_REQ requesters with
// round-robin priority, holds the winning command on the port until the
// memory acknowledges or the timeout expires, then pulses done to the owner.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ack
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [IDX_W-1:0]    r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_count;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_pick_valid;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_grant;
    logic                w_ack_done;
    logic                w_timeout;

    // The last owner doubles as the round-robin pointer.
    mem_bus_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .i_req    (req),
        .i_ptr    (r_owner),
        .o_valid  (w_pick_valid),
        .o_winner (w_pick_idx)
    );

    // State register; reset drops mem_req at once because mem_req decodes it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the grant / completion events that drive the datapath.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_ack_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // An ack on the final allowed cycle still counts as success.
                if (mem_ack) begin
                    w_ack_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (r_count == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Command latches, timeout counter, response pulses and read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the command latches feed the memory port directly, so
            // they are reset too; otherwise mem_* would come up undefined.
            r_owner <= IDX_W'(NUM_REQ - 1);
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_count <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here update
            // from pre-edge values, independent of statement order.
            r_gnt  <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
            if (w_grant) begin
                r_owner <= w_pick_idx;
                r_we    <= we[w_pick_idx];
                r_addr  <= addr[w_pick_idx*ADDR_W +: ADDR_W];
                r_wdata <= wdata[w_pick_idx*DATA_W +: DATA_W];
                r_count <= '0;
                r_gnt   <= NUM_REQ'(1) << w_pick_idx;
            end else if (r_state == ST_BUSY) begin
                r_count <= r_count + 1'b1;
            end
            if (w_ack_done || w_timeout) begin
                r_done <= NUM_REQ'(1) << r_owner;
                r_err  <= w_timeout;
            end
            if (w_ack_done && !r_we) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = (r_state == ST_BUSY);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;

endmodule
